// File: rtl/cart_pkg.sv
// cart_pkg: shared types and constants for the cartridge image loader.
//   load_state_t : parser state, also exported on the loader's debug port
//   load_err_t   : failure reason reported on error_code_out
//   DEFAULT_MAGIC: first byte every valid image must start with
package cart_pkg;

  typedef enum logic [2:0] {
    S_MAGIC   = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_SUM_HI  = 3'd4,
    S_SUM_LO  = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } load_state_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_MAGIC = 3'd1,
    ERR_LEN   = 3'd2,
    ERR_SUM   = 3'd3,
    ERR_TRUNC = 3'd4
  } load_err_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // DONE and ERROR hold until reset; nothing further is parsed there.
  function automatic logic is_terminal(input load_state_t s);
    return (s == S_DONE) || (s == S_ERROR);
  endfunction

endpackage

// File: rtl/cart_loader.sv
// cart_loader: parses a framed cartridge image from the ROM reader byte
// stream, writes the payload into program RAM, verifies a 16-bit additive
// checksum and releases the CPU from reset only for a good image.
//
// Image: MAGIC, LEN_HI, LEN_LO, LEN payload bytes, SUM_HI, SUM_LO.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   byte_valid_in, byte_in  one-cycle byte strobe and data from the reader
//   rom_finished_in         level: reader has delivered its last byte
//   mem_we_out/addr/data    program RAM write port (one-cycle pulse)
//   cpu_reset_out           high until a good image has been accepted
//   load_done_out           image loaded and checksum matched
//   load_error_out          load failed; error_code_out gives the reason
//   checksum_out            running payload sum
//   dbg_state_out           current parser state (load_state_t)
//
// Handshake: byte_valid_in is a bare strobe with no ready. The reader
// cannot be stalled, so every strobe in a non-terminal state is consumed
// in the cycle it arrives; back-to-back strobes give one write per cycle.
module cart_loader
  import cart_pkg::*;
#(
  parameter int         RAM_ADDR_W = 14,
  parameter logic [7:0] MAGIC      = DEFAULT_MAGIC
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  byte_valid_in,
  input  logic [7:0]            byte_in,
  input  logic                  rom_finished_in,
  output logic                  mem_we_out,
  output logic [RAM_ADDR_W-1:0] mem_addr_out,
  output logic [7:0]            mem_data_out,
  output logic                  cpu_reset_out,
  output logic                  load_done_out,
  output logic                  load_error_out,
  output logic [2:0]            error_code_out,
  output logic [15:0]           checksum_out,
  output logic [2:0]            dbg_state_out
);

  // Largest image that fits the RAM; 17 bits so 2**16 is representable.
  localparam logic [16:0] MAX_LEN = 17'd1 << RAM_ADDR_W;

  load_state_t           r_state;
  load_err_t             r_err;
  logic [15:0]           r_len;
  logic [15:0]           r_count;
  logic [RAM_ADDR_W-1:0] r_addr;
  logic [RAM_ADDR_W-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic                  r_we;
  logic [7:0]            r_sum_hi;
  logic [15:0]           r_checksum;

  load_state_t           w_next_state;
  load_err_t             w_next_err;
  logic                  w_pay_wr;
  logic                  w_len_start;
  logic [15:0]           w_len_full;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_MAGIC;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_next_err;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_err   = r_err;
    w_pay_wr     = 1'b0;
    w_len_start  = 1'b0;
    w_len_full   = {r_len[15:8], byte_in};
    if (!is_terminal(r_state)) begin
      // A byte in the same cycle as finished wins; finished is seen again
      // next cycle once the strobe is gone.
      if (byte_valid_in) begin
        case (r_state)
          S_MAGIC: begin
            if (byte_in == MAGIC) begin
              w_next_state = S_LEN_HI;
            end else begin
              w_next_state = S_ERROR;
              w_next_err   = ERR_MAGIC;
            end
          end
          S_LEN_HI: w_next_state = S_LEN_LO;
          S_LEN_LO: begin
            if ({1'b0, w_len_full} > MAX_LEN) begin
              w_next_state = S_ERROR;
              w_next_err   = ERR_LEN;
            end else if (w_len_full == 16'd0) begin
              w_next_state = S_SUM_HI;
            end else begin
              w_next_state = S_PAYLOAD;
              w_len_start  = 1'b1;
            end
          end
          S_PAYLOAD: begin
            w_pay_wr = 1'b1;
            // r_count is the number of payload bytes already taken.
            if (r_count == r_len - 16'd1) begin
              w_next_state = S_SUM_HI;
            end
          end
          S_SUM_HI: w_next_state = S_SUM_LO;
          S_SUM_LO: begin
            if ({r_sum_hi, byte_in} == r_checksum) begin
              w_next_state = S_DONE;
            end else begin
              w_next_state = S_ERROR;
              w_next_err   = ERR_SUM;
            end
          end
          default: ;
        endcase
      end else if (rom_finished_in) begin
        w_next_state = S_ERROR;
        w_next_err   = ERR_TRUNC;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_len      <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_we       <= 1'b0;
      r_sum_hi   <= '0;
      r_checksum <= '0;
    end else begin
      r_we <= w_pay_wr;
      if (byte_valid_in && (r_state == S_LEN_HI)) r_len[15:8] <= byte_in;
      if (byte_valid_in && (r_state == S_LEN_LO)) r_len[7:0]  <= byte_in;
      if (byte_valid_in && (r_state == S_SUM_HI)) r_sum_hi    <= byte_in;
      if (w_len_start) begin
        r_count <= '0;
        r_addr  <= '0;
      end
      if (w_pay_wr) begin
        // r_addr may roll over after a full-RAM image, but that value is
        // never presented on the write port.
        r_wr_addr  <= r_addr;
        r_wr_data  <= byte_in;
        r_addr     <= r_addr + RAM_ADDR_W'(1);
        r_count    <= r_count + 16'd1;
        r_checksum <= r_checksum + {8'h00, byte_in};
      end
    end
  end

  assign mem_we_out     = r_we;
  assign mem_addr_out   = r_wr_addr;
  assign mem_data_out   = r_wr_data;
  assign load_done_out  = (r_state == S_DONE);
  assign load_error_out = (r_state == S_ERROR);
  assign cpu_reset_out  = (r_state != S_DONE);
  assign error_code_out = r_err;
  assign checksum_out   = r_checksum;
  assign dbg_state_out  = r_state;

endmodule
